// File: rtl/gen_sec.sv
// Serial frame transmitter: sends SECUENCIA, the latched payload and SEC_REINICIO,
// MSB first, one bit per clock on a registered s_out, then pulses listo.
module gen_sec #(
  parameter logic [4:0] SECUENCIA    = 5'b10100,
  parameter logic [4:0] SEC_REINICIO = 5'b00000,
  parameter int         DATOS_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [DATOS_W-1:0] datos,
  output logic               s_out,
  output logic               ocupado,
  output logic               listo
);

  // Handshake: inicio is a level request; it is accepted on a rising edge only
  // while the state is INICIO (including the listo cycle) and never queued.
  // datos is sampled on that accepting edge and ignored at all other times.

  typedef enum logic [3:0] {
    INICIO    = 4'b0001,
    PREAMBULO = 4'b0010,
    DATOS     = 4'b0100,
    REINICIO  = 4'b1000
  } state_t;

  localparam logic [4:0] LAST_DATA = 5'(DATOS_W - 1);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [DATOS_W-1:0] tx_q, tx_d;
  logic               s_out_d, ocupado_d, listo_d;
  logic [2:0]         pat_idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    s_out_d   = 1'b0;
    ocupado_d = 1'b0;
    listo_d   = 1'b0;
    // Pattern bit for the next cycle: bit 4 goes out on field entry, so the
    // counter value c selects bit 3-c on the following edge.
    pat_idx   = 3'd3 - cnt_q[2:0];

    case (state_q)
      INICIO: begin
        if (inicio) begin
          state_d   = PREAMBULO;
          cnt_d     = 5'd0;
          tx_d      = datos;
          s_out_d   = SECUENCIA[4];
          ocupado_d = 1'b1;
        end
      end

      PREAMBULO: begin
        ocupado_d = 1'b1;
        if (cnt_q == 5'd4) begin
          state_d = DATOS;
          cnt_d   = 5'd0;
          s_out_d = tx_q[DATOS_W-1];
          tx_d    = tx_q << 1;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          s_out_d = SECUENCIA[pat_idx];
        end
      end

      DATOS: begin
        ocupado_d = 1'b1;
        if (cnt_q == LAST_DATA) begin
          state_d = REINICIO;
          cnt_d   = 5'd0;
          s_out_d = SEC_REINICIO[4];
        end else begin
          cnt_d   = cnt_q + 5'd1;
          s_out_d = tx_q[DATOS_W-1];
          tx_d    = tx_q << 1;
        end
      end

      REINICIO: begin
        if (cnt_q == 5'd4) begin
          state_d = INICIO;
          cnt_d   = 5'd0;
          listo_d = 1'b1;
        end else begin
          ocupado_d = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          s_out_d   = SEC_REINICIO[pat_idx];
        end
      end

      default: begin
        state_d = INICIO;
        cnt_d   = 5'd0;
        tx_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INICIO;
      cnt_q   <= 5'd0;
      tx_q    <= '0;
      s_out   <= 1'b0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      s_out   <= s_out_d;
      ocupado <= ocupado_d;
      listo   <= listo_d;
    end
  end

endmodule

// File: tb/tb_gen_sec.sv
// Bench for gen_sec: a frame-level model expands each accepted start into the
// expected per-cycle {s_out, ocupado, listo} stream held in exp_q.
module tb_gen_sec;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         inicio = 1'b0;
  logic [W-1:0] datos = '0;
  logic         s_out, ocupado, listo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] cur = 3'b000;
  logic [4:0] sec_pat = 5'b10100;
  logic [4:0] rel_pat = 5'b00000;
  logic [17:0] golden_a5 = 18'b10100_10100101_00000;

  gen_sec #(
    .SECUENCIA(5'b10100),
    .SEC_REINICIO(5'b00000),
    .DATOS_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inicio(inicio),
    .datos(datos),
    .s_out(s_out),
    .ocupado(ocupado),
    .listo(listo)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge, then the DUT; returns at the negedge.
  task automatic step();
    if (!rst) begin
      exp_q.delete();
      cur = 3'b000;
    end else begin
      if (!cur[1] && inicio) begin
        for (int i = 4; i >= 0; i--) exp_q.push_back({sec_pat[i], 2'b10});
        for (int i = W - 1; i >= 0; i--) exp_q.push_back({datos[i], 2'b10});
        for (int i = 4; i >= 0; i--) exp_q.push_back({rel_pat[i], 2'b10});
        exp_q.push_back(3'b001);
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = 3'b000;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inicio = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 2) rst = 1'b1;
      step();
      total++;
      if ({s_out, ocupado, listo} !== 3'b000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=000", cyc, {s_out, ocupado, listo});
      end
    end
  endtask

  task automatic test_single_frame();
    logic [17:0] stream = '0;
    int busy = 0;
    int listo_at = -1;
    datos = 8'hA5;
    inicio = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      inicio = 1'b0;
      datos = W'($urandom);
      total++;
      if ({s_out, ocupado, listo} !== cur) begin
        bad++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc, {s_out, ocupado, listo}, cur);
      end
      if (i <= 18) stream = {stream[16:0], s_out};
      if (ocupado) busy++;
      if (listo && listo_at < 0) listo_at = i;
    end
    total++;
    if (stream !== golden_a5) begin
      bad++;
      $display("FAIL single_stream got=%b exp=%b", stream, golden_a5);
    end
    total++;
    if (busy != 18) begin
      bad++;
      $display("FAIL single_busy got=%0d exp=18", busy);
    end
    total++;
    if (listo_at != 19) begin
      bad++;
      $display("FAIL single_listo got=%0d exp=19", listo_at);
    end
  endtask

  task automatic test_ignored_start();
    logic [17:0] stream = '0;
    int listos = 0;
    datos = 8'hA5;
    inicio = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 1) datos = 8'hFF;
      if (i == 11) inicio = 1'b0;
      total++;
      if ({s_out, ocupado, listo} !== cur) begin
        bad++;
        $display("FAIL ignored_start cyc=%0d got=%b exp=%b", cyc, {s_out, ocupado, listo}, cur);
      end
      if (i <= 18) stream = {stream[16:0], s_out};
      if (listo) listos++;
    end
    total++;
    if (stream !== golden_a5) begin
      bad++;
      $display("FAIL ignored_stream got=%b exp=%b", stream, golden_a5);
    end
    total++;
    if (listos != 1) begin
      bad++;
      $display("FAIL ignored_listo_count got=%0d exp=1", listos);
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int listos = 0;
    datos = 8'h3C;
    inicio = 1'b1;
    for (int i = 1; i <= 57; i++) begin
      step();
      total++;
      if ({s_out, ocupado, listo} !== cur) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {s_out, ocupado, listo}, cur);
      end
      if (listo) begin
        listos++;
        total++;
        if (last >= 0 && i - last != 19) begin
          bad++;
          $display("FAIL b2b_period got=%0d exp=19", i - last);
        end
        last = i;
      end
    end
    inicio = 1'b0;
    total++;
    if (listos != 3) begin
      bad++;
      $display("FAIL b2b_listo_count got=%0d exp=3", listos);
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_abort();
    int listos = 0;
    datos = W'($urandom);
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({s_out, ocupado, listo} !== 3'b000) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d got=%b exp=000", cyc, {s_out, ocupado, listo});
      end
      if (listo) listos++;
      step();
    end
    total++;
    if (listos != 0) begin
      bad++;
      $display("FAIL abort_listo got=%0d exp=0", listos);
    end
    datos = 8'h5A;
    inicio = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      inicio = 1'b0;
      total++;
      if ({s_out, ocupado, listo} !== cur) begin
        bad++;
        $display("FAIL abort_refill cyc=%0d got=%b exp=%b", cyc, {s_out, ocupado, listo}, cur);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      inicio = ($urandom_range(0, 3) == 0);
      datos = W'($urandom);
      rst = ($urandom_range(0, 149) != 0);
      step();
      total++;
      if ({s_out, ocupado, listo} !== cur) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {s_out, ocupado, listo}, cur);
      end
    end
    rst = 1'b1;
    inicio = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
